// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, constants and width helper for the debounce scan controller
package debounce_pkg;

    localparam logic RST_LEVEL_DEF = 1'b1;

    typedef enum logic {ST_IDLE, ST_HOLD} evt_state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deb_rr_arbiter.sv
// deb_rr_arbiter: combinational round-robin picker over pending flags, searching from last+1
module deb_rr_arbiter
    import debounce_pkg::*;
#(
    parameter int N_CH = 8,
    localparam int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last,
    output logic [CH_W-1:0] gnt,
    output logic            any
);

    logic [CH_W-1:0] c;

    assign any = |req;

    // walk from the farthest candidate back to last+1 so the nearest request wins
    always_comb begin
        gnt = '0;
        c   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            c = CH_W'((int'(last) + i) % N_CH);
            if (req[c]) gnt = c;
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: round-robin scanned multi-channel debouncer with a valid/ready event port.
// Define DEB_SCAN_OVF_EN to add sticky per-channel overflow flags (ovf) with a clear input (ovf_clr).
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int   N_CH      = 8,
    parameter int   TICK_DIV  = 1000,
    parameter int   DEPTH     = 3,
    parameter logic RST_LEVEL = RST_LEVEL_DEF,
    localparam int  CH_W      = ch_w(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_level
`ifdef DEB_SCAN_OVF_EN
    ,
    input  logic            ovf_clr,
    output logic [N_CH-1:0] ovf
`endif
);

    localparam int PW = ch_w(TICK_DIV);

    logic [N_CH-1:0]  sync1, sync2, pend, flip, flip_q, load_mask;
    logic [DEPTH-1:0] hist [N_CH];
    logic [DEPTH-1:0] shifted;
    logic [PW-1:0]    presc;
    logic [CH_W-1:0]  ptr, last_grant, gnt;
    logic             step, any, load;
    evt_state_t       state, state_nx;

    assign step    = en && (presc == PW'(TICK_DIV - 1));
    assign shifted = {hist[ptr][DEPTH-2:0], sync2[ptr]};

    always_comb begin
        flip      = '0;
        flip[ptr] = step && (out[ptr] ? (shifted == '0) : (&shifted));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= {N_CH{RST_LEVEL}};
            sync2 <= {N_CH{RST_LEVEL}};
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            ptr   <= '0;
            out   <= {N_CH{RST_LEVEL}};
            for (int k = 0; k < N_CH; k++) hist[k] <= {DEPTH{RST_LEVEL}};
        end else begin
            presc <= step ? '0 : en ? presc + 1'b1 : presc;
            out   <= out ^ flip;
            if (step) begin
                hist[ptr] <= shifted;
                ptr       <= (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

    deb_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req  (pend),
        .last (last_grant),
        .gnt  (gnt),
        .any  (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == ST_IDLE) ? (any ? ST_HOLD : ST_IDLE)
                                      : (evt_ready ? ST_IDLE : ST_HOLD);
    end

    always_comb begin
        evt_valid      = (state == ST_HOLD);
        load           = (state == ST_IDLE) && any;
        load_mask      = '0;
        load_mask[gnt] = load;
    end

    // a flip registered in the load cycle re-arms the flag, so set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_q     <= '0;
            pend       <= '0;
            evt_ch     <= '0;
            evt_level  <= 1'b0;
            last_grant <= '0;
        end else begin
            flip_q <= flip;
            pend   <= (pend & ~load_mask) | flip_q;
            if (load) begin
                evt_ch    <= gnt;
                evt_level <= out[gnt];
            end
            if (evt_valid && evt_ready) last_grant <= evt_ch;
        end
    end

`ifdef DEB_SCAN_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= '0;
        else        ovf <= (ovf & ~{N_CH{ovf_clr}}) | (flip_q & pend & ~load_mask);
    end
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: directed and randomized checks against a run-length reference model
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DP = 3;

    logic       clk = 1'b0;
    logic       rst_n, en, evt_ready, ovf_clr;
    logic [3:0] din;
    logic [3:0] out, ovf;
    logic       evt_valid, evt_level;
    logic [1:0] evt_ch;

    int checks = 0;
    int errors = 0;
    int seen   = 0;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(.N_CH(N), .TICK_DIV(TD), .DEPTH(DP), .RST_LEVEL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (din),
        .out       (out),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_level (evt_level)
`ifdef DEB_SCAN_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf       (ovf)
`endif
    );

`ifndef DEB_SCAN_OVF_EN
    assign ovf = '0;
`endif

    // reference model: a channel flips once its latest DP samples all disagree with its level
    bit [3:0] ms1, ms2, mout, mfq, mpend, movf, nout, nfq, npend;
    bit       mbusy, mlvl, b, mstep;
    bit       last_s [N];
    int       run [N];
    int       mcnt, mptr, mch, mlast, g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms1 = 4'hF; ms2 = 4'hF; mout = 4'hF;
            mfq = 0; mpend = 0; movf = 0;
            mbusy = 0; mlvl = 0; mcnt = 0; mptr = 0; mch = 0; mlast = 0;
            for (int k = 0; k < N; k++) begin run[k] = DP; last_s[k] = 1'b1; end
        end else begin
            mstep = en && (mcnt == TD - 1);
            nout = mout; nfq = 0;
            if (mstep) begin
                b = ms2[mptr];
                run[mptr] = (b == last_s[mptr]) ? run[mptr] + 1 : 1;
                last_s[mptr] = b;
                if (run[mptr] >= DP && b != mout[mptr]) begin
                    nout[mptr] = b;
                    nfq[mptr]  = 1'b1;
                end
                mptr = (mptr + 1) % N;
            end
            mcnt = !en ? mcnt : mstep ? 0 : mcnt + 1;
            npend = mpend; g = -1;
            if (mbusy) begin
                if (evt_ready) begin mbusy = 0; mlast = mch; end
            end else begin
                for (int i = 1; i <= N; i++)
                    if (g < 0 && mpend[(mlast + i) % N]) g = (mlast + i) % N;
                if (g >= 0) begin mbusy = 1; mch = g; mlvl = mout[g]; npend[g] = 0; end
            end
            if (ovf_clr) movf = 0;
            for (int k = 0; k < N; k++) begin
                if (mfq[k] && mpend[k] && k != g) movf[k] = 1'b1;
                if (mfq[k]) npend[k] = 1'b1;
            end
            ms2 = ms1; ms1 = din;
            mout = nout; mfq = nfq; mpend = npend;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        check("out", 32'(out), 32'(mout));
        check("evt_valid", 32'(evt_valid), 32'(mbusy));
        check("evt_ch", 32'(evt_ch), 32'(mch));
        check("evt_level", 32'(evt_level), 32'(mlvl));
`ifdef DEB_SCAN_OVF_EN
        check("ovf", 32'(ovf), 32'(movf));
`endif
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmp_all();
            if (evt_valid) seen++;
        end
    endtask

    logic [3:0] frozen;
    int         waited;

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 4'hF; evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'hF);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_ch", 32'(evt_ch), 32'h0);
        check("rst_level", 32'(evt_level), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1; en = 1'b1;

        cyc(200);
        check("idle_out", 32'(out), 32'hF);
        check("idle_no_evt", 32'(seen), 32'h0);

        din[2] = 1'b0;
        cyc(32);
        din[2] = 1'b1;
        cyc(64);
        check("glitch_out2", 32'(out[2]), 32'h1);
        check("glitch_no_evt", 32'(seen), 32'h0);

        din[2] = 1'b0;
        waited = 0;
        while (!evt_valid && waited < 200) begin cyc(1); waited++; end
        check("fall_evt_seen", 32'(evt_valid), 32'h1);
        check("fall_out2", 32'(out[2]), 32'h0);
        check("fall_ch", 32'(evt_ch), 32'h2);
        check("fall_level", 32'(evt_level), 32'h0);
        cyc(10);
        check("hold_valid", 32'(evt_valid), 32'h1);
        check("hold_ch", 32'(evt_ch), 32'h2);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        check("accept_valid", 32'(evt_valid), 32'h0);
        cyc(20);

        en = 1'b0;
        frozen = out;
        for (int i = 0; i < 100; i++) begin din[0] = ~din[0]; cyc(1); end
        check("en0_out", 32'(out), 32'(frozen));
        en = 1'b1;
        din[0] = 1'b1;
        cyc(100);

        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) if ($urandom_range(0, 63) == 0) din[k] = ~din[k];
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) evt_ready = ~evt_ready;
            ovf_clr = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        en = 1'b1; ovf_clr = 1'b0; evt_ready = 1'b0;

        din = 4'h0;
        waited = 0;
        while (!evt_valid && waited < 400) begin cyc(1); waited++; end
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_valid), 32'h0);
        check("async_rst_out", 32'(out), 32'hF);
        @(negedge clk);
        din = 4'hF; rst_n = 1'b1;
        cyc(100);
        check("post_rst_no_evt_out", 32'(out), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
